// File: rtl/flash_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// flash_cmd_sequencer
//
// Turns single-byte host commands into SPI flash transactions and streams the
// flash response bytes back to the host.
//   "I" (0x49) : JEDEC ID read (0x9F), 3 response bytes
//   "S" (0x53) : status register read (0x05), 1 response byte
//   "R" (0x52) : followed by addr[23:0] and len[15:0] (MSB first), issues a
//                read (0x03) and returns len bytes (len = 0 means 65536)
// Unknown opcodes and argument timeouts give a one-cycle error pulse.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   in_data, in_strobe    : host command bytes, one per strobe, no backpressure
//   out_data, out_valid,
//   out_ready             : response byte stream (transfer on valid & ready)
//   spi_enable            : holds flash CS asserted for the whole command
//   spi_tx_data,
//   spi_tx_strobe,
//   spi_tx_ready          : byte transmit request to the SPI controller
//   spi_rx_data,
//   spi_rx_strobe         : one received byte per transmitted byte
//   busy                  : sequencer not idle
//   error                 : one-cycle pulse on bad opcode or argument timeout
// -----------------------------------------------------------------------------
module flash_cmd_sequencer #(
    parameter int TIMEOUT = 9600000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_strobe,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       spi_enable,
    output logic [7:0] spi_tx_data,
    output logic       spi_tx_strobe,
    input  logic       spi_tx_ready,
    input  logic [7:0] spi_rx_data,
    input  logic       spi_rx_strobe,
    output logic       busy,
    output logic       error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, ARGS, CMD, ADDR, DATA, WAIT_RX, WAIT_OUT, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    arg_cnt_q, arg_cnt_d;
    logic [31:0]   arg_buf_q, arg_buf_d;
    logic [7:0]    opcode_q, opcode_d;
    logic          is_read_q, is_read_d;
    logic [23:0]   addr_q, addr_d;
    logic [16:0]   count_q, count_d;
    logic [1:0]    addr_idx_q, addr_idx_d;
    // Responses still owed for opcode/address bytes; these are discarded.
    logic [2:0]    pending_q, pending_d;
    logic          tx_strobe_q;
    logic          enable_q, enable_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          error_q, error_d;

    logic          tx_fire;
    logic          hdr_fire;
    logic          tx_allowed;
    logic [7:0]    tx_byte;
    logic          rx_discard;

    // The strobe is a Mealy output of spi_tx_ready so it can never be issued
    // while the controller is not ready; the registered copy of the previous
    // strobe keeps two strobes from landing on adjacent cycles.
    assign tx_allowed = spi_tx_ready && !tx_strobe_q && !reset;
    assign rx_discard = spi_rx_strobe && (pending_q != 3'd0);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        timer_d     = timer_q;
        arg_cnt_d   = arg_cnt_q;
        arg_buf_d   = arg_buf_q;
        opcode_d    = opcode_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        count_d     = count_q;
        addr_idx_d  = addr_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        error_d     = 1'b0;
        tx_fire     = 1'b0;
        hdr_fire    = 1'b0;
        tx_byte     = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (in_strobe) begin
                    unique case (in_data)
                        8'h49: begin
                            opcode_d  = 8'h9F;
                            count_d   = 17'd3;
                            is_read_d = 1'b0;
                            state_d   = CMD;
                        end
                        8'h53: begin
                            opcode_d  = 8'h05;
                            count_d   = 17'd1;
                            is_read_d = 1'b0;
                            state_d   = CMD;
                        end
                        8'h52: begin
                            arg_cnt_d = 3'd0;
                            timer_d   = '0;
                            state_d   = ARGS;
                        end
                        default: error_d = 1'b1;
                    endcase
                end
            end

            ARGS: begin
                if (in_strobe) begin
                    timer_d   = '0;
                    arg_buf_d = {arg_buf_q[23:0], in_data};
                    arg_cnt_d = arg_cnt_q + 3'd1;
                    if (arg_cnt_q == 3'd4) begin
                        // Buffer holds addr[23:0], len[15:8]; in_data is len[7:0].
                        addr_d    = arg_buf_q[31:8];
                        count_d   = ({arg_buf_q[7:0], in_data} == 16'h0000) ?
                                    17'h10000 : {1'b0, arg_buf_q[7:0], in_data};
                        opcode_d  = 8'h03;
                        is_read_d = 1'b1;
                        state_d   = CMD;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            CMD: begin
                // CS is raised on entry, so the opcode always goes out under it.
                tx_byte = opcode_q;
                if (enable_q && tx_allowed) begin
                    tx_fire    = 1'b1;
                    hdr_fire   = 1'b1;
                    addr_idx_d = 2'd0;
                    state_d    = is_read_q ? ADDR : DATA;
                end
            end

            ADDR: begin
                unique case (addr_idx_q)
                    2'd0:    tx_byte = addr_q[23:16];
                    2'd1:    tx_byte = addr_q[15:8];
                    default: tx_byte = addr_q[7:0];
                endcase
                if (tx_allowed) begin
                    tx_fire    = 1'b1;
                    hdr_fire   = 1'b1;
                    addr_idx_d = addr_idx_q + 2'd1;
                    if (addr_idx_q == 2'd2) state_d = DATA;
                end
            end

            DATA: begin
                if (count_q == 17'd0) begin
                    state_d = DONE;
                end else if (tx_allowed) begin
                    tx_fire = 1'b1;
                    count_d = count_q - 17'd1;
                    state_d = WAIT_RX;
                end
            end

            WAIT_RX: begin
                if (spi_rx_strobe && pending_q == 3'd0) begin
                    out_data_d  = spi_rx_data;
                    out_valid_d = 1'b1;
                    state_d     = WAIT_OUT;
                end
            end

            WAIT_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = (count_q != 17'd0) ? DATA : DONE;
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase

        pending_d = pending_q;
        if (hdr_fire && !rx_discard) pending_d = pending_q + 3'd1;
        else if (!hdr_fire && rx_discard) pending_d = pending_q - 3'd1;

        enable_d = state_d inside {CMD, ADDR, DATA, WAIT_RX, WAIT_OUT};
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the values from before this edge, independent of order.
        if (reset) begin
            // NOTE: the whole datapath is reset, not just the FSM, so no stale
            // arguments or response byte survive an aborted command.
            state_q     <= IDLE;
            timer_q     <= '0;
            arg_cnt_q   <= '0;
            arg_buf_q   <= '0;
            opcode_q    <= '0;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            count_q     <= '0;
            addr_idx_q  <= '0;
            pending_q   <= '0;
            tx_strobe_q <= 1'b0;
            enable_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            arg_cnt_q   <= arg_cnt_d;
            arg_buf_q   <= arg_buf_d;
            opcode_q    <= opcode_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            addr_idx_q  <= addr_idx_d;
            pending_q   <= pending_d;
            tx_strobe_q <= tx_fire;
            enable_q    <= enable_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            error_q     <= error_d;
        end
    end

    assign spi_enable    = enable_q;
    assign spi_tx_strobe = tx_fire;
    assign spi_tx_data   = tx_fire ? tx_byte : 8'h00;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign error         = error_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_flash_cmd_sequencer
//
// Drives host command bytes into flash_cmd_sequencer against a small SPI flash
// model (fixed latency per byte, JEDEC ID EF 40 18, status 0x5A, memory byte
// = xor of the address bytes ^ 0x3C) and checks the SPI byte log, the response
// stream, error pulses and CS behaviour.
// -----------------------------------------------------------------------------
module tb_flash_cmd_sequencer;

    localparam int TIMEOUT = 40;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_strobe;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       spi_enable;
    logic [7:0] spi_tx_data;
    logic       spi_tx_strobe;
    logic       spi_tx_ready;
    logic [7:0] spi_rx_data;
    logic       spi_rx_strobe;
    logic       busy;
    logic       error;

    flash_cmd_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_strobe    (in_strobe),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .spi_enable   (spi_enable),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_strobe(spi_tx_strobe),
        .spi_tx_ready (spi_tx_ready),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_strobe(spi_rx_strobe),
        .busy         (busy),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] spi_log[$];
    logic [7:0] out_log[$];
    int         proto_err = 0;
    int         stab_err  = 0;
    int         err_cnt   = 0;
    int         en_cycles = 0;
    int         en_rise   = 0;

    logic [23:0] id_word = 24'hEF4018;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    // ---------------- SPI flash model ----------------
    logic [7:0]  m_op;
    logic [23:0] m_addr;
    logic [7:0]  m_resp;
    int          m_idx;
    int          m_timer;
    logic        m_busy;
    logic        m_prev;

    always @(posedge clk) begin
        spi_rx_strobe <= 1'b0;
        if (reset) begin
            spi_tx_ready <= 1'b1;
            m_busy = 1'b0;
            m_idx  = 0;
            m_prev = 1'b0;
        end else begin
            if (!spi_enable && !spi_tx_strobe) m_idx = 0;
            if (spi_tx_strobe) begin
                if (!spi_tx_ready || m_prev || !spi_enable) proto_err++;
                spi_log.push_back(spi_tx_data);
                m_resp = 8'hFF;
                if (m_idx == 0) m_op = spi_tx_data;
                else if (m_op == 8'h9F && m_idx <= 3) m_resp = id_word[8*(3-m_idx) +: 8];
                else if (m_op == 8'h05) m_resp = 8'h5A;
                else if (m_op == 8'h03 && m_idx <= 3) m_addr = {m_addr[15:0], spi_tx_data};
                else if (m_op == 8'h03) m_resp = mem_byte(m_addr + 24'(m_idx - 4));
                m_idx++;
                m_busy  = 1'b1;
                m_timer = 3;
                spi_tx_ready <= 1'b0;
            end else if (m_busy) begin
                m_timer--;
                if (m_timer == 0) begin
                    spi_rx_strobe <= 1'b1;
                    spi_rx_data   <= m_resp;
                    spi_tx_ready  <= 1'b1;
                    m_busy = 1'b0;
                end
            end
            m_prev = spi_tx_strobe;
        end
    end

    // ---------------- output / CS monitor ----------------
    logic       hold_prev;
    logic [7:0] hold_data;
    logic       en_prev;

    always @(posedge clk) begin
        if (reset) begin
            hold_prev = 1'b0;
            en_prev   = 1'b0;
        end else begin
            if (out_valid && out_ready) out_log.push_back(out_data);
            if (hold_prev && (!out_valid || out_data != hold_data)) stab_err++;
            if (error) err_cnt++;
            if (spi_enable) en_cycles++;
            if (spi_enable && !en_prev) en_rise++;
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            en_prev   = spi_enable;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_data   = b;
        in_strobe = 1'b1;
        @(negedge clk);
        in_strobe = 1'b0;
        in_data   = 8'h00;
    endtask

    task automatic clear_logs();
        spi_log.delete();
        out_log.delete();
        err_cnt   = 0;
        en_cycles = 0;
        en_rise   = 0;
    endtask

    task automatic wait_idle(input int budget, input string what);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(what, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_out(input int cnt, input int budget, input string what);
        int n = 0;
        while (out_log.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(what, {31'd0, out_log.size() >= cnt}, 32'd1);
    endtask

    task automatic check_read_stream(input string tag, input logic [23:0] addr, input int len);
        check({tag, "_out_len"}, out_log.size(), len);
        for (int k = 0; k < len && k < out_log.size(); k++)
            check($sformatf("%s_out%0d", tag, k), out_log[k], mem_byte(addr + 24'(k)));
    endtask

    // ---------------- table ----------------
    typedef struct packed {
        logic [47:0] seq;     // host bytes, first byte in [47:40]
        logic [2:0]  n_in;
        logic [7:0]  exp_out;
        logic [7:0]  exp_spi;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [7:0] exp_out_byte(input vec_t v, input int k);
        logic [23:0] a;
        a = v.seq[39:16];
        case (v.seq[47:40])
            8'h49:   return id_word[8*(2-k) +: 8];
            8'h53:   return 8'h5A;
            default: return mem_byte(a + 24'(k));
        endcase
    endfunction

    function automatic logic [7:0] exp_spi_byte(input vec_t v, input int j);
        if (j == 0) begin
            case (v.seq[47:40])
                8'h49:   return 8'h9F;
                8'h53:   return 8'h05;
                default: return 8'h03;
            endcase
        end
        if (v.seq[47:40] == 8'h52 && j <= 3) return v.seq[47-8*j -: 8];
        return 8'h00;
    endfunction

    initial begin
        vec_t v;
        int   n_spi;

        vecs[0] = '{seq: {8'h49, 40'h0},                 n_in: 3'd1, exp_out: 8'd3, exp_spi: 8'd4, exp_err: 1'b0};
        vecs[1] = '{seq: {8'h53, 40'h0},                 n_in: 3'd1, exp_out: 8'd1, exp_spi: 8'd2, exp_err: 1'b0};
        vecs[2] = '{seq: {8'h58, 40'h0},                 n_in: 3'd1, exp_out: 8'd0, exp_spi: 8'd0, exp_err: 1'b1};
        vecs[3] = '{seq: 48'h52_01_02_03_00_04,          n_in: 3'd6, exp_out: 8'd4, exp_spi: 8'd8, exp_err: 1'b0};
        vecs[4] = '{seq: 48'h52_00_FF_FE_00_03,          n_in: 3'd6, exp_out: 8'd3, exp_spi: 8'd7, exp_err: 1'b0};
        vecs[5] = '{seq: {8'h69, 40'h0},                 n_in: 3'd1, exp_out: 8'd0, exp_spi: 8'd0, exp_err: 1'b1};

        reset     = 1'b1;
        in_data   = 8'h00;
        in_strobe = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_spi_enable", {31'd0, spi_enable}, 32'd0);
        check("rst_tx_strobe",  {31'd0, spi_tx_strobe}, 32'd0);
        check("rst_tx_data",    {24'd0, spi_tx_data}, 32'd0);
        check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_out_data",   {24'd0, out_data}, 32'd0);
        check("rst_busy",       {31'd0, busy}, 32'd0);
        check("rst_error",      {31'd0, error}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven commands.
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            clear_logs();
            for (int k = 0; k < int'(v.n_in); k++) send_byte(v.seq[47-8*k -: 8]);
            wait_idle(2000, $sformatf("vec%0d_idle", i));
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_out_len", i), out_log.size(), v.exp_out);
            check($sformatf("vec%0d_spi_len", i), spi_log.size(), v.exp_spi);
            check($sformatf("vec%0d_err", i), err_cnt, v.exp_err);
            check($sformatf("vec%0d_cs_count", i), en_rise, v.exp_err ? 0 : 1);
            for (int k = 0; k < int'(v.exp_out) && k < out_log.size(); k++)
                check($sformatf("vec%0d_out%0d", i, k), out_log[k], exp_out_byte(v, k));
            for (int j = 0; j < int'(v.exp_spi) && j < spi_log.size(); j++)
                check($sformatf("vec%0d_spi%0d", i, j), spi_log[j], exp_spi_byte(v, j));
        end

        // Argument timeout: error pulse, CS never raised.
        clear_logs();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        repeat (TIMEOUT - 5) @(negedge clk);
        check("to_no_early_err", err_cnt, 0);
        check("to_busy_before",  {31'd0, busy}, 32'd1);
        repeat (10) @(negedge clk);
        check("to_err_pulse", err_cnt, 1);
        check("to_busy_after", {31'd0, busy}, 32'd0);
        check("to_no_cs", en_cycles, 0);

        // Timer restarts on every argument byte.
        clear_logs();
        send_byte(8'h52);
        foreach (id_word[b]) ; // no-op keeps loop vars local below
        for (int k = 0; k < 5; k++) begin
            repeat (TIMEOUT - 5) @(negedge clk);
            case (k)
                2:       send_byte(8'h40);
                4:       send_byte(8'h01);
                default: send_byte(8'h00);
            endcase
        end
        wait_idle(2000, "gap_idle");
        repeat (3) @(negedge clk);
        check("gap_err", err_cnt, 0);
        check_read_stream("gap", 24'h000040, 1);

        // Backpressure: out_ready low for 500 cycles mid-stream.
        clear_logs();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h06);
        wait_out(2, 500, "bp_first_two");
        out_ready = 1'b0;
        repeat (20) @(negedge clk);
        n_spi = spi_log.size();
        repeat (480) @(negedge clk);
        check("bp_spi_frozen", spi_log.size(), n_spi);
        check("bp_out_valid",  {31'd0, out_valid}, 32'd1);
        check("bp_stable",     stab_err, 0);
        out_ready = 1'b1;
        wait_idle(2000, "bp_idle");
        repeat (3) @(negedge clk);
        check_read_stream("bp", 24'h000100, 6);
        check("bp_spi_len", spi_log.size(), 10);

        // "S" during an active read is ignored.
        clear_logs();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h08);
        wait_out(2, 500, "ign_first_two");
        send_byte(8'h53);
        wait_idle(2000, "ign_idle");
        repeat (3) @(negedge clk);
        check_read_stream("ign", 24'h000020, 8);
        check("ign_spi_len", spi_log.size(), 12);
        check("ign_err", err_cnt, 0);

        // Reset in the data phase, then a normal "S".
        clear_logs();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        wait_out(3, 500, "rmid_three");
        reset = 1'b1;
        @(negedge clk);
        check("rmid_cs_low",     {31'd0, spi_enable}, 32'd0);
        check("rmid_valid_low",  {31'd0, out_valid}, 32'd0);
        check("rmid_busy_low",   {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        clear_logs();
        send_byte(8'h53);
        wait_idle(2000, "rmid_s_idle");
        repeat (3) @(negedge clk);
        check("rmid_s_out_len", out_log.size(), 1);
        if (out_log.size() > 0) check("rmid_s_out0", out_log[0], 8'h5A);
        check("rmid_s_spi_len", spi_log.size(), 2);
        if (spi_log.size() > 0) check("rmid_s_spi0", spi_log[0], 8'h05);

        check("spi_protocol", proto_err, 0);
        check("out_stability", stab_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
